// File: rtl/stream_joiner.sv
// Joins NUM_S parallel branch streams into one wide beat, one holding register per branch.
// Also measures arrival skew between branches and raises a sticky debug flag when it is excessive.
module stream_joiner #(
    parameter int NUM_S      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int SKEW_MAX   = 15
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_S-1:0]            s_valid,
    output logic [NUM_S-1:0]            s_ready,
    input  logic [NUM_S*DATA_WIDTH-1:0] s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [NUM_S*DATA_WIDTH-1:0] m_data,
    output logic [NUM_S-1:0]            pending,
    output logic                        skew_err
);

    localparam int               CNT_W   = $clog2(SKEW_MAX + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SKEW_MAX + 1);

    logic [NUM_S-1:0]            r_full;
    logic [NUM_S*DATA_WIDTH-1:0] r_data;
    logic [CNT_W-1:0]            r_skew_cnt;
    logic                        r_skew_err;

    logic                        w_pop;
    logic [NUM_S-1:0]            w_cap;
    logic [CNT_W-1:0]            w_skew_cnt_nxt;

    // Handshake decode; s_ready depends only on state and m_ready, never on s_valid.
    always_comb begin
        w_pop   = (&r_full) & m_ready;
        s_ready = ~r_full | {NUM_S{w_pop}};
        w_cap   = s_valid & s_ready;
    end

    // Skew counter runs only while the join is partially filled, saturating one past the limit.
    always_comb begin
        w_skew_cnt_nxt = {CNT_W{1'b0}};
        if ((|r_full) && !(&r_full)) begin
            if (r_skew_cnt == CNT_SAT) begin
                w_skew_cnt_nxt = r_skew_cnt;
            end else begin
                w_skew_cnt_nxt = r_skew_cnt + CNT_W'(1);
            end
        end else begin
            w_skew_cnt_nxt = {CNT_W{1'b0}};
        end
    end

    // Per-branch holding registers; a capture in the pop cycle refills the slot immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_full <= {NUM_S{1'b0}};
            r_data <= {(NUM_S*DATA_WIDTH){1'b0}};
        end else begin
            for (int i = 0; i < NUM_S; i++) begin
                if (w_cap[i]) begin
                    r_data[i*DATA_WIDTH +: DATA_WIDTH] <= s_data[i*DATA_WIDTH +: DATA_WIDTH];
                    r_full[i]                          <= 1'b1;
                end else if (w_pop) begin
                    r_full[i] <= 1'b0;
                end else begin
                    r_full[i] <= r_full[i];
                end
            end
        end
    end

    // Skew tracking; the error flag is sticky until reset and never touches the datapath.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_skew_cnt <= {CNT_W{1'b0}};
            r_skew_err <= 1'b0;
        end else begin
            r_skew_cnt <= w_skew_cnt_nxt;
            r_skew_err <= r_skew_err | (w_skew_cnt_nxt == CNT_SAT);
        end
    end

    assign m_valid  = &r_full;
    assign m_data   = r_data;
    assign pending  = r_full;
    assign skew_err = r_skew_err;

endmodule

// File: tb/tb_stream_joiner.sv
// Directed and randomised checks of stream_joiner with two 32-bit branches.
module tb_stream_joiner;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  s_valid;
    logic [1:0]  s_ready;
    logic [63:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [1:0]  pending;
    logic        skew_err;

    int total = 0;
    int bad   = 0;

    stream_joiner #(.NUM_S(2), .DATA_WIDTH(32), .SKEW_MAX(15)) dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .pending(pending), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sv;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        mr;
        logic [1:0]  e_pend;
        logic        e_mv;
        logic [1:0]  e_rdy;
        logic [63:0] e_data;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] sv, input logic [31:0] d0, input logic [31:0] d1,
                         input logic mr);
        s_valid = sv;
        s_data  = {d1, d0};
        m_ready = mr;
    endtask

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] qexp[$];
    int          out_cnt;
    int          cyc;
    logic [31:0] v;

    initial begin
        resetn = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        chk("rst_pending", {62'd0, pending}, 64'd0);
        chk("rst_mvalid", {63'd0, m_valid}, 64'd0);
        chk("rst_sready", {62'd0, s_ready}, 64'd3);
        chk("rst_mdata", m_data, 64'd0);
        chk("rst_skew_err", {63'd0, skew_err}, 64'd0);

        // inputs / expected outputs seen in that same cycle (before its capture edge)
        tbl[0]  = '{2'b11, 32'hA5A5_0001, 32'h0000_0002, 1'b1, 2'b00, 1'b0, 2'b11, 64'h0};
        tbl[1]  = '{2'b00, 32'h0, 32'h0, 1'b0, 2'b11, 1'b1, 2'b00, 64'h0000_0002_A5A5_0001};
        tbl[2]  = '{2'b11, 32'h1111_1111, 32'h2222_2222, 1'b0, 2'b11, 1'b1, 2'b00, 64'h0000_0002_A5A5_0001};
        tbl[3]  = '{2'b11, 32'h1111_1111, 32'h2222_2222, 1'b0, 2'b11, 1'b1, 2'b00, 64'h0000_0002_A5A5_0001};
        tbl[4]  = '{2'b11, 32'h3333_3333, 32'h4444_4444, 1'b1, 2'b11, 1'b1, 2'b11, 64'h0000_0002_A5A5_0001};
        tbl[5]  = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b11, 1'b1, 2'b11, 64'h4444_4444_3333_3333};
        tbl[6]  = '{2'b01, 32'h5555_5555, 32'h0, 1'b1, 2'b00, 1'b0, 2'b11, 64'h4444_4444_3333_3333};
        tbl[7]  = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b01, 1'b0, 2'b10, 64'h4444_4444_5555_5555};
        tbl[8]  = '{2'b10, 32'h0, 32'h6666_6666, 1'b0, 2'b01, 1'b0, 2'b10, 64'h4444_4444_5555_5555};
        tbl[9]  = '{2'b00, 32'h0, 32'h0, 1'b0, 2'b11, 1'b1, 2'b00, 64'h6666_6666_5555_5555};
        tbl[10] = '{2'b00, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 1'b1, 2'b11, 1'b1, 2'b11, 64'h6666_6666_5555_5555};
        tbl[11] = '{2'b00, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 1'b0, 2'b00, 1'b0, 2'b11, 64'h6666_6666_5555_5555};

        for (int r = 0; r < 12; r++) begin
            @(posedge clk); #1;
            drive(tbl[r].sv, tbl[r].d0, tbl[r].d1, tbl[r].mr);
            @(negedge clk);
            chk($sformatf("tbl%0d_pending", r), {62'd0, pending}, {62'd0, tbl[r].e_pend});
            chk($sformatf("tbl%0d_mvalid", r), {63'd0, m_valid}, {63'd0, tbl[r].e_mv});
            chk($sformatf("tbl%0d_sready", r), {62'd0, s_ready}, {62'd0, tbl[r].e_rdy});
            chk($sformatf("tbl%0d_mdata", r), m_data, tbl[r].e_data);
        end

        // back-to-back streaming: beat c appears exactly one cycle after it is offered
        for (int c = 0; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c < 8) drive(2'b11, 32'h0000_0100 + c, 32'h0000_0200 + c, 1'b1);
            else drive(2'b00, 32'h0, 32'h0, 1'b1);
            @(negedge clk);
            if (c >= 1 && c <= 8) begin
                chk($sformatf("stream%0d_mvalid", c), {63'd0, m_valid}, 64'd1);
                chk($sformatf("stream%0d_mdata", c), m_data,
                    {32'h0000_0200 + 32'(c - 1), 32'h0000_0100 + 32'(c - 1)});
            end else if (c == 9) begin
                chk("stream_end_mvalid", {63'd0, m_valid}, 64'd0);
            end
        end

        // skewed arrival: branch0 at cycle 0, branch1 at cycle 5
        for (int c = 0; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive(2'b01, 32'hAAAA_0000, 32'h0, 1'b0);
            else if (c == 5) drive(2'b10, 32'h0, 32'hBBBB_0001, 1'b0);
            else if (c == 6) drive(2'b00, 32'h0, 32'h0, 1'b1);
            else drive(2'b00, 32'h0, 32'h0, 1'b0);
            @(negedge clk);
            if (c >= 1 && c <= 5) begin
                chk($sformatf("skew%0d_pending", c), {62'd0, pending}, 64'd1);
                chk($sformatf("skew%0d_sready0", c), {63'd0, s_ready[0]}, 64'd0);
                chk($sformatf("skew%0d_mvalid", c), {63'd0, m_valid}, 64'd0);
            end else if (c == 6) begin
                chk("skew6_mvalid", {63'd0, m_valid}, 64'd1);
                chk("skew6_mdata", m_data, 64'hBBBB_0001_AAAA_0000);
            end else if (c == 7) begin
                chk("skew7_mvalid", {63'd0, m_valid}, 64'd0);
            end
        end
        chk("skew_ok_no_err", {63'd0, skew_err}, 64'd0);

        // excessive skew: branch1 idle for 16 cycles after branch0 captured
        for (int c = 0; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive(2'b01, 32'hC0DE_0000, 32'h0, 1'b0);
            else if (c == 18) drive(2'b10, 32'h0, 32'hC0DE_0001, 1'b0);
            else if (c == 19) drive(2'b00, 32'h0, 32'h0, 1'b1);
            else drive(2'b00, 32'h0, 32'h0, 1'b0);
            @(negedge clk);
            if (c == 16) chk("skerr16", {63'd0, skew_err}, 64'd0);
            if (c == 17) chk("skerr17", {63'd0, skew_err}, 64'd1);
            if (c == 19) begin
                chk("skerr_beat_mvalid", {63'd0, m_valid}, 64'd1);
                chk("skerr_beat_mdata", m_data, 64'hC0DE_0001_C0DE_0000);
            end
            if (c == 20) chk("skerr_sticky", {63'd0, skew_err}, 64'd1);
        end

        // async reset mid-cycle with one branch held
        @(posedge clk); #1;
        drive(2'b01, 32'hDEAD_0000, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        chk("pre_rst_pending", {62'd0, pending}, 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_pending", {62'd0, pending}, 64'd0);
        chk("async_rst_mvalid", {63'd0, m_valid}, 64'd0);
        chk("async_rst_sready", {62'd0, s_ready}, 64'd3);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_skew_err", {63'd0, skew_err}, 64'd0);
        chk("post_rst_pending", {62'd0, pending}, 64'd0);

        // splitter loopback: each beat fanned to both branches through random delays
        for (int i = 0; i < 1000; i++) begin
            v = (32'(i) << 16) | 32'($urandom_range(0, 65535));
            q0.push_back(v);
            q1.push_back(v);
            qexp.push_back(v);
        end
        out_cnt = 0;
        cyc = 0;
        while (out_cnt < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            s_valid[0] = (q0.size() > 0) && ($urandom_range(0, 3) != 0);
            s_valid[1] = (q1.size() > 0) && ($urandom_range(0, 3) != 0);
            s_data     = {(q1.size() > 0) ? q1[0] : 32'h0, (q0.size() > 0) ? q0[0] : 32'h0};
            m_ready    = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (s_valid[0] && s_ready[0]) void'(q0.pop_front());
            if (s_valid[1] && s_ready[1]) void'(q1.pop_front());
            if (m_valid && m_ready) begin
                v = qexp.pop_front();
                chk($sformatf("loop%0d_mdata", out_cnt), m_data, {v, v});
                out_cnt++;
            end
            cyc++;
        end
        chk("loop_beat_count", 64'(out_cnt), 64'd1000);
        drive(2'b00, 32'h0, 32'h0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("loop_no_extra", {63'd0, m_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
